// File: rtl/uart_reset_sequencer.sv
// UART-controlled target reset sequencer: 'A' triggers a delayed reset pulse,
// 'W'/'D' followed by a big-endian 16-bit argument program width and delay.
module uart_reset_sequencer #(
    parameter logic [15:0] DEFAULT_WIDTH = 16'd16,
    parameter logic [15:0] DEFAULT_DELAY = 16'd0,
    parameter int unsigned ARG_TIMEOUT   = 1200000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        target_rst_n,
    output logic        busy,
    output logic        done,
    output logic        cmd_err,
    output logic [15:0] cfg_width,
    output logic [15:0] cfg_delay
);

    localparam int TW = $clog2(ARG_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(ARG_TIMEOUT - 1);

    typedef enum logic [1:0] {P_IDLE, P_HI, P_LO} p_state_t;
    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_PULSE} s_state_t;

    p_state_t        p_state;
    s_state_t        s_state;
    logic [TW-1:0]   tmo_cnt;
    logic            sel_width;
    logic [7:0]      arg_hi;
    logic [15:0]     s_cnt;
    logic [15:0]     w_lat;

    logic trig, seq_free, trig_ok, trig_rej, tmo_fire;

    function automatic logic [15:0] eff_width(input logic [15:0] w);
        return (w == 16'd0) ? 16'd1 : w;
    endfunction

    // Argument bytes never decode as commands, so triggers only come from P_IDLE.
    assign trig     = rx_valid && (p_state == P_IDLE) && (rx_data == 8'h41);
    assign seq_free = (s_state == S_IDLE) || ((s_state == S_PULSE) && (s_cnt == 16'd0));
    assign trig_ok  = trig && seq_free;
    assign trig_rej = trig && !seq_free;
    assign tmo_fire = (p_state != P_IDLE) && !rx_valid && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_state   <= P_IDLE;
            tmo_cnt   <= '0;
            cmd_err   <= 1'b0;
            cfg_width <= DEFAULT_WIDTH;
            cfg_delay <= DEFAULT_DELAY;
        end else begin
            cmd_err <= tmo_fire || trig_rej;
            case (p_state)
                P_IDLE: begin
                    if (rx_valid && (rx_data == 8'h57 || rx_data == 8'h44)) begin
                        sel_width <= (rx_data == 8'h57);
                        tmo_cnt   <= '0;
                        p_state   <= P_HI;
                    end
                end
                P_HI: begin
                    if (rx_valid) begin
                        arg_hi  <= rx_data;
                        tmo_cnt <= '0;
                        p_state <= P_LO;
                    end else if (tmo_fire) begin
                        p_state <= P_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                P_LO: begin
                    if (rx_valid) begin
                        if (sel_width) cfg_width <= {arg_hi, rx_data};
                        else           cfg_delay <= {arg_hi, rx_data};
                        p_state <= P_IDLE;
                    end else if (tmo_fire) begin
                        p_state <= P_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                default: p_state <= P_IDLE;
            endcase
        end
    end

    // s_cnt holds the remaining cycles of the current phase minus one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_state      <= S_IDLE;
            s_cnt        <= 16'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            target_rst_n <= 1'b1;
        end else begin
            done <= 1'b0;
            case (s_state)
                S_DELAY: begin
                    if (s_cnt == 16'd0) begin
                        s_state      <= S_PULSE;
                        target_rst_n <= 1'b0;
                        s_cnt        <= w_lat - 16'd1;
                    end else begin
                        s_cnt <= s_cnt - 16'd1;
                    end
                end
                S_PULSE: begin
                    if (s_cnt == 16'd0) begin
                        s_state      <= S_IDLE;
                        target_rst_n <= 1'b1;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                    end else begin
                        s_cnt <= s_cnt - 16'd1;
                    end
                end
                default: ;
            endcase
            if (trig_ok) begin
                busy  <= 1'b1;
                w_lat <= eff_width(cfg_width);
                if (cfg_delay == 16'd0) begin
                    s_state      <= S_PULSE;
                    target_rst_n <= 1'b0;
                    s_cnt        <= eff_width(cfg_width) - 16'd1;
                end else begin
                    s_state      <= S_DELAY;
                    target_rst_n <= 1'b1;
                    s_cnt        <= cfg_delay - 16'd1;
                end
            end
        end
    end

endmodule
